// File: rtl/lsb_mem_ctrl.sv
// lsb_mem_ctrl: responder for load/store-buffer memory tasks. Each task is
// carried out as a little-endian, byte-serial access on the 8-bit RAM port.
// Loads return zero-extended data together with a one-cycle lsb_done pulse.
// Build option MEMCTRL_IO_STALL_EN: an IO-space store (addr[17:16] == 2'b11)
// waits while io_buffer_full is high. Without the macro io_buffer_full is ignored.
module lsb_mem_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic                  lsb_signal,
    input  logic                  lsb_wr,
    input  logic [1:0]            lsb_len,
    input  logic [ADDR_WIDTH-1:0] lsb_addr,
    input  logic [DATA_WIDTH-1:0] lsb_dout,
    output logic [DATA_WIDTH-1:0] lsb_din,
    output logic                  lsb_done,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr,
    input  logic                  io_buffer_full
);
    localparam int NBYTES = DATA_WIDTH / 8;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_step;
    logic [2:0]            w_step_next;
    logic [2:0]            r_cnt;
    logic [2:0]            w_len_cnt;
    logic                  r_cooldown;
    logic                  w_accept;
    logic                  w_io_stall;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic [DATA_WIDTH-1:0] r_result;
    logic [7:0]            w_wr_byte;
    logic [2:0]            w_cap_idx;

`ifdef MEMCTRL_IO_STALL_EN
    // A store to IO space holds its current byte while the IO write buffer is full.
    assign w_io_stall = (r_state == WRITE) && (r_addr[17:16] == 2'b11) && io_buffer_full;
`else
    logic w_unused_io_full;
    assign w_io_stall       = 1'b0;
    assign w_unused_io_full = io_buffer_full;
`endif

    // The byte count is 1, 2 or 4; both 10 and 11 mean a full word.
    assign w_len_cnt = (lsb_len == 2'b00) ? 3'd1 :
                       (lsb_len == 2'b01) ? 3'd2 : 3'd4;

    // A read step k stores the byte that was addressed during step k-1.
    assign w_cap_idx = r_step - 3'd1;

    // Next-state logic: IDLE accepts a request unless it is in the cooldown cycle after DONE.
    always_comb begin
        w_state_next = r_state;
        w_step_next  = r_step;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (lsb_signal && !r_cooldown) begin
                    w_accept     = 1'b1;
                    w_step_next  = 3'd0;
                    w_state_next = lsb_wr ? WRITE : READ;
                end
            end
            READ: begin
                if (r_step == r_cnt) begin
                    w_state_next = DONE;
                end else begin
                    w_step_next = r_step + 3'd1;
                end
            end
            WRITE: begin
                if (!w_io_stall) begin
                    w_step_next = r_step + 3'd1;
                    if (r_step == r_cnt - 3'd1) begin
                        w_state_next = DONE;
                    end
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Select the store byte for the current write step (little-endian).
    always_comb begin
        w_wr_byte = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (r_step == b[2:0]) begin
                w_wr_byte = r_data[8*b +: 8];
            end
        end
    end

    // Control and result registers. All of them freeze while rdy_in is low.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state    <= IDLE;
            r_step     <= 3'd0;
            r_cnt      <= 3'd0;
            r_cooldown <= 1'b0;
            r_result   <= '0;
        end else if (rdy_in) begin
            r_state    <= w_state_next;
            r_step     <= w_step_next;
            r_cooldown <= (r_state == DONE);
            if (w_accept) begin
                r_cnt    <= w_len_cnt;
                r_result <= '0;
            end
            if (r_state == READ && r_step != 3'd0) begin
                for (int b = 0; b < NBYTES; b++) begin
                    if (w_cap_idx == b[2:0]) begin
                        r_result[8*b +: 8] <= ram_din;
                    end
                end
            end
        end
    end

    // Latch the request address and store data. These are only observed during READ or WRITE.
    always_ff @(posedge clk_in) begin
        if (rdy_in && w_accept) begin
            r_addr <= lsb_addr;
            r_data <= lsb_dout;
        end
    end

    // RAM port and completion outputs, decoded from the frozen state so they hold during a pause.
    always_comb begin
        ram_a    = '0;
        ram_dout = 8'h00;
        ram_wr   = 1'b0;
        lsb_done = 1'b0;
        case (r_state)
            READ: begin
                ram_a = r_addr + ADDR_WIDTH'(r_step);
            end
            WRITE: begin
                ram_a    = r_addr + ADDR_WIDTH'(r_step);
                ram_dout = w_wr_byte;
                ram_wr   = rdy_in && !w_io_stall;
            end
            DONE: begin
                lsb_done = rdy_in;
            end
            default: begin
                ram_a = '0;
            end
        endcase
    end

    assign lsb_din = r_result;

endmodule

// File: tb/tb_lsb_mem_ctrl.sv
// tb_lsb_mem_ctrl: directed and randomized tasks compared against a byte-array memory model.
module tb_lsb_mem_ctrl;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef MEMCTRL_IO_STALL_EN
    localparam bit IOSTALL = 1'b1;
`else
    localparam bit IOSTALL = 1'b0;
`endif

    logic          clk_in         = 1'b0;
    logic          rst_in         = 1'b0;
    logic          rdy_in         = 1'b1;
    logic          lsb_signal     = 1'b0;
    logic          lsb_wr         = 1'b0;
    logic [1:0]    lsb_len        = 2'b00;
    logic [AW-1:0] lsb_addr       = '0;
    logic [DW-1:0] lsb_dout       = '0;
    logic [DW-1:0] lsb_din;
    logic          lsb_done;
    logic [7:0]    ram_din        = 8'h00;
    logic [7:0]    ram_dout;
    logic [AW-1:0] ram_a;
    logic          ram_wr;
    logic          io_buffer_full = 1'b0;

    lsb_mem_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .lsb_signal(lsb_signal), .lsb_wr(lsb_wr), .lsb_len(lsb_len),
        .lsb_addr(lsb_addr), .lsb_dout(lsb_dout), .lsb_din(lsb_din),
        .lsb_done(lsb_done), .ram_din(ram_din), .ram_dout(ram_dout),
        .ram_a(ram_a), .ram_wr(ram_wr), .io_buffer_full(io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // ram_mem is the RAM the DUT talks to; ref_mem is the model's view of memory.
    logic [7:0]  ram_mem [logic [31:0]];
    logic [7:0]  ref_mem [logic [31:0]];
    logic [31:0] wq_a[$];
    logic [7:0]  wq_d[$];
    int          wr_events = 0;

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        if (ram_mem.exists(a)) return ram_mem[a];
        return init_byte(a);
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_byte(a);
    endfunction

    task automatic poke(input logic [31:0] a, input logic [7:0] v);
        ram_mem[a] = v;
        ref_mem[a] = v;
    endtask

    // Synchronous-read RAM. It shares the system pause, so it only clocks on active cycles.
    always @(posedge clk_in) begin
        if (rdy_in) begin
            ram_din <= ram_rd(ram_a);
            if (rst_in && ram_wr) begin
                ram_mem[ram_a] = ram_dout;
                wq_a.push_back(ram_a);
                wq_d.push_back(ram_dout);
                wr_events++;
            end
        end
    end

    // Issue one task and check the per-cycle RAM port, latency, result and write list.
    task automatic run_task(input string nm, input bit wr, input logic [1:0] len,
                            input logic [31:0] addr, input logic [31:0] data,
                            input int p_at, input int p_len, input int io_at, input int io_len,
                            input bit late, output logic [31:0] din);
        int n; int c; int k; int stalls; int exp_lat; int n_exp_wr;
        bit got; bit stall;
        logic [31:0] exp_res;
        n = (len == 2'b00) ? 1 : (len == 2'b01) ? 2 : 4;
        exp_res = '0;
        if (!wr) for (int i = 0; i < n; i++) exp_res[8*i +: 8] = ref_rd(addr + 32'(i));
        @(negedge clk_in);
        wq_a.delete();
        wq_d.delete();
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        lsb_signal = 1'b1; lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_dout = data;
        c = 0; k = 0; stalls = 0; got = 1'b0;
        while (!got && c < 60) begin
            @(negedge clk_in);
            c++;
            rdy_in = !(p_at > 0 && c >= p_at && c < p_at + p_len);
            io_buffer_full = (io_at > 0 && c >= io_at && c < io_at + io_len);
            lsb_wr   = 1'($urandom);
            lsb_len  = 2'($urandom);
            lsb_addr = $urandom;
            lsb_dout = $urandom;
            #1;
            if (lsb_done) begin
                got = 1'b1;
            end else begin
                stall = !rdy_in || (IOSTALL && wr && addr[17:16] == 2'b11 && io_buffer_full);
                if (k < n) begin
                    chk({nm, " ram_a"}, ram_a, addr + 32'(k));
                    chk({nm, " ram_wr"}, 32'(ram_wr), 32'(wr && !stall));
                    if (wr) chk({nm, " ram_dout"}, 32'(ram_dout), 32'(data[8*k +: 8]));
                    if (stall) stalls++;
                    else k++;
                end else if (!wr && k == n) begin
                    chk({nm, " ram_wr"}, 32'(ram_wr), 32'd0);
                    if (!rdy_in) stalls++;
                    else k++;
                end
            end
        end
        lsb_wr = wr; lsb_len = len; lsb_addr = addr; lsb_dout = data;
        rdy_in = 1'b1;
        io_buffer_full = 1'b0;
        exp_lat = (wr ? n + 1 : n + 2) + stalls;
        chk({nm, " done seen"}, 32'(got), 32'd1);
        chk({nm, " latency"}, c, exp_lat);
        din = lsb_din;
        chk({nm, " lsb_din"}, lsb_din, wr ? 32'd0 : exp_res);
        n_exp_wr = wr ? n : 0;
        chk({nm, " write count"}, wq_a.size(), n_exp_wr);
        for (int i = 0; i < n_exp_wr && i < wq_a.size(); i++) begin
            chk({nm, " write addr"}, wq_a[i], addr + 32'(i));
            chk({nm, " write data"}, 32'(wq_d[i]), 32'(data[8*i +: 8]));
        end
        if (wr) for (int i = 0; i < n; i++) ref_mem[addr + 32'(i)] = data[8*i +: 8];
        @(negedge clk_in);
        if (!late) lsb_signal = 1'b0;
        #1;
        chk({nm, " done width"}, 32'(lsb_done), 32'd0);
    endtask

    task automatic idle_chk(input int cyc);
        int w0;
        w0 = wr_events;
        repeat (cyc) begin
            @(negedge clk_in);
            lsb_signal = 1'b0;
            rdy_in = 1'b1;
            #1;
            chk("idle done", 32'(lsb_done), 32'd0);
        end
        chk("idle writes", wr_events, w0);
    endtask

    initial begin
        logic [31:0] din;
        int w0;
        repeat (2) @(negedge clk_in);
        #1;
        chk("rst lsb_done", 32'(lsb_done), 32'd0);
        chk("rst lsb_din", lsb_din, 32'd0);
        chk("rst ram_a", ram_a, 32'd0);
        chk("rst ram_dout", 32'(ram_dout), 32'd0);
        chk("rst ram_wr", 32'(ram_wr), 32'd0);
        rst_in = 1'b1;

        poke(32'h1000, 8'h11); poke(32'h1001, 8'h22);
        poke(32'h1002, 8'h33); poke(32'h1003, 8'h44);
        run_task("lw", 1'b0, 2'b10, 32'h1000, 32'h0, 0, 0, 0, 0, 1'b0, din);
        chk("lw value", din, 32'h4433_2211);

        run_task("sb", 1'b1, 2'b00, 32'h2001, 32'hAABB_CCDD, 0, 0, 0, 0, 1'b0, din);
        run_task("sh", 1'b1, 2'b01, 32'h2002, 32'hAABB_CCDD, 0, 0, 0, 0, 1'b0, din);
        chk("sb mem", 32'(ram_rd(32'h2001)), 32'hDD);
        chk("sh mem lo", 32'(ram_rd(32'h2002)), 32'hDD);
        chk("sh mem hi", 32'(ram_rd(32'h2003)), 32'hCC);

        poke(32'hFFFF_FFFF, 8'h80);
        poke(32'h0000_0000, 8'h7F);
        run_task("lbu wrap", 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0, 1'b0, din);
        chk("lbu value", din, 32'h0000_0080);
        run_task("lh wrap", 1'b0, 2'b01, 32'hFFFF_FFFF, 32'h0, 0, 0, 0, 0, 1'b0, din);
        chk("lh value", din, 32'h0000_7F80);

        run_task("sw pause", 1'b1, 2'b10, 32'h3000, 32'h1234_5678, 2, 3, 0, 0, 1'b0, din);
        run_task("lw pause", 1'b0, 2'b10, 32'h3000, 32'h0, 2, 3, 0, 0, 1'b0, din);
        chk("lw pause value", din, 32'h1234_5678);

        run_task("sw late", 1'b1, 2'b11, 32'h3100, 32'hCAFE_F00D, 0, 0, 0, 0, 1'b1, din);
        run_task("lw after late", 1'b0, 2'b10, 32'h3100, 32'h0, 0, 0, 0, 0, 1'b0, din);
        chk("lw after late value", din, 32'hCAFE_F00D);
        idle_chk(2);

        // Reset in the middle of a word load, once two bytes have been captured.
        @(negedge clk_in);
        lsb_signal = 1'b1; lsb_wr = 1'b0; lsb_len = 2'b10; lsb_addr = 32'h1000;
        repeat (4) @(negedge clk_in);
        w0 = wr_events;
        rst_in = 1'b0;
        lsb_signal = 1'b0;
        #1;
        chk("mid rst lsb_done", 32'(lsb_done), 32'd0);
        chk("mid rst lsb_din", lsb_din, 32'd0);
        chk("mid rst ram_a", ram_a, 32'd0);
        chk("mid rst ram_wr", 32'(ram_wr), 32'd0);
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        idle_chk(8);
        chk("mid rst writes", wr_events, w0);

        run_task("sb io", 1'b1, 2'b00, 32'h0003_0000, 32'h0000_005A, 0, 0, 1, 5, 1'b0, din);
        chk("sb io mem", 32'(ram_rd(32'h0003_0000)), 32'h5A);

        for (int t = 0; t < 40; t++) begin
            logic [31:0] a;
            logic [1:0]  ln;
            bit          w;
            bit          lt;
            int          n;
            int          pa;
            int          pl;
            int          ia;
            int          il;
            case ($urandom_range(0, 3))
                0:       a = 32'hFFFF_FFFC + $urandom_range(0, 3);
                1, 2:    a = 32'h0000_4000 + $urandom_range(0, 31);
                default: a = 32'h0003_0000 + $urandom_range(0, 7);
            endcase
            ln = 2'($urandom_range(0, 3));
            w  = 1'($urandom_range(0, 1));
            lt = 1'($urandom_range(0, 1));
            n  = (ln == 2'b00) ? 1 : (ln == 2'b01) ? 2 : 4;
            pa = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
            pl = int'($urandom_range(1, 3));
            ia = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, n)) : 0;
            il = int'($urandom_range(1, 4));
            run_task(w ? "rand st" : "rand ld", w, ln, a, $urandom, pa, pl, ia, il, lt, din);
            if ($urandom_range(0, 3) == 0) idle_chk(1);
        end
        idle_chk(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
